lut_cfg_readback: RTL
=====================

// Module: lut_cfg_readback
// PURPOSE
//  Reads back the configuration image held in the LUT/mux configuration store and
//  streams it out serially as a framed bitstream (header, payload words, CRC-8).
//  Counterpart to configuration load: lets benches and debug logic verify what was
//  written into the fabric. Sits between the config store read port and a serial link.
// PARAMETERS
//  NUM_WORDS  24  number of configuration words in the image (addresses 0..NUM_WORDS-1)
//  WORD_W     33  bits per word ({flag bit, 32-bit truth table})
//  ADDR_W     5   config store address width; must satisfy 2**ADDR_W >= NUM_WORDS
// PORTS
//  clock         in   1       single clock, rising edge
//  reset         in   1       asynchronous, active-high reset
//  start         in   1       1-cycle request to begin a readback frame
//  busy          out  1       high from the cycle after accepted start until done
//  done          out  1       1-cycle pulse after last CRC bit is transferred
//  mem_rd_en     out  1       config store read strobe
//  mem_addr      out  ADDR_W  config store read address
//  mem_rdata     in   WORD_W  read data, valid exactly 1 cycle after mem_rd_en
//  serial_out    out  1       current stream bit
//  serial_valid  out  1       serial_out holds a valid bit
//  serial_ready  in   1       sink accepts; bit transfers when valid && ready
// BEHAVIOUR
//  - Reset (any time, async): all outputs 0, state IDLE, counters/CRC cleared;
//    a frame in progress is abandoned, no done pulse.
//  - Frame = 8-bit header 8'hA5 MSB first, then words addr 0..NUM_WORDS-1 each MSB
//    (bit WORD_W-1) first, then 8-bit CRC MSB first. Length 8+NUM_WORDS*WORD_W+8 bits.
//  - CRC-8: poly x^8+x^2+x+1 (8'h07), init 8'h00, no reflect, no final XOR,
//    computed bitwise over payload bits only (header and CRC excluded).
//  - FSM: IDLE -> HDR -> FETCH -> WAIT -> SHIFT -> (FETCH | CRC) -> DONE -> IDLE.
//    IDLE: start accepted -> HDR, busy=1. start while busy is ignored.
//    HDR: shifts 8 header bits under handshake.
//    FETCH: mem_rd_en=1 for one cycle with mem_addr=word index; serial_valid=0.
//    WAIT: captures mem_rdata into shift register at end of cycle; serial_valid=0.
//    SHIFT: WORD_W bits; after last bit -> FETCH for next index, or CRC after index
//      NUM_WORDS-1. CRC: 8 bits. DONE: done=1, busy=0 for one cycle, -> IDLE.
//  - Handshake: serial_out must not change while serial_valid && !serial_ready;
//    serial_valid never drops mid-field except in FETCH/WAIT gaps between fields.
//    CRC register updates only on an accepted payload bit.
//  - mem_rd_en issued exactly once per word, addresses strictly increasing from 0;
//    mem_addr holds last value when idle (0 after reset).
//  - Bit counters size to ceil(log2(WORD_W+1)); word index wraps never (stops at last).
// STRUCTURE
//  - Package lut_cfg_pkg: CFG_HDR=8'hA5, CRC8_POLY=8'h07, state enum type,
//    default WORD_W/NUM_WORDS constants shared with config-load logic.
//  - Sub-module crc8_serial (clock, reset, clear, en, bit_in, crc[7:0]).
//  - Top holds FSM, word/bit counters, WORD_W shift register.
// TESTING
//  1. Reset held, then released with start=0 -> busy/done/serial_valid/mem_rd_en=0,
//     mem_addr=0; no activity for 50 cycles.
//  2. Store all zeros, ready=1, start -> bits 10100101, 792 zeros, CRC 00000000;
//     808 transfers total, done pulses once, busy low after.
//  3. Words 0..7={0,CCCCAAAA}, 8..15={0,FF00F0F0}, 16..19={0,FAFAA0A0},
//     20..23={0,A5A55A5A} -> payload bit-exact MSB first; CRC equals bench model.
//  4. serial_ready low 5 cycles mid-word and random 50% elsewhere -> serial_out
//     stable while stalled, no bit lost or duplicated, same stream as test 3.
//  5. mem_addr/mem_rd_en monitor -> addresses 0..23 in order, one strobe each,
//     rdata sampled exactly 1 cycle later; start pulsed during busy is ignored.
//  6. Assert reset mid word 10 -> outputs 0 same edge; new start -> full frame
//     from header, CRC identical to test 3.

Source files
------------

// File: rtl/lut_cfg_pkg.sv
// lut_cfg_pkg
//   Constants and types shared by the configuration readback path and the
//   configuration load logic: frame header, CRC polynomial, default image
//   geometry, readback state encoding and a single-bit CRC-8 step.
package lut_cfg_pkg;

  localparam logic [7:0] CFG_HDR       = 8'hA5;
  localparam logic [7:0] CRC8_POLY     = 8'h07;
  localparam int         CRC_W         = 8;
  localparam int         DEF_WORD_W    = 33;
  localparam int         DEF_NUM_WORDS = 24;
  localparam int         DEF_ADDR_W    = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_FETCH = 3'd2,
    ST_WAIT  = 3'd3,
    ST_SHIFT = 3'd4,
    ST_CRC   = 3'd5,
    ST_DONE  = 3'd6
  } rb_state_t;

  // MSB-first CRC-8 update for one message bit, no reflection.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
    logic fb;
    fb = crc[7] ^ bit_in;
    return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/lut_cfg_readback_crc.sv
// crc8_serial
//   Bit-serial CRC-8 (poly 0x07, init 0x00) accumulator.
// Ports
//   clock   in   rising-edge clock
//   reset   in   async active-high reset, clears crc
//   clear   in   synchronous clear to init value
//   en      in   fold bit_in into the CRC this cycle
//   bit_in  in   message bit
//   crc     out  current CRC value
module crc8_serial
  import lut_cfg_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] crc
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      crc <= 8'h00;
    end else if (clear) begin
      crc <= 8'h00;
    end else if (en) begin
      crc <= crc8_step(crc, bit_in);
    end
  end

endmodule

// File: rtl/lut_cfg_readback.sv
// lut_cfg_readback
//   Reads the configuration image out of the config store and streams it as a
//   framed serial bitstream: header 0xA5, NUM_WORDS words MSB first, CRC-8 over
//   the payload. Bits move on serial_valid && serial_ready.
// Ports
//   clock         in   rising-edge clock
//   reset         in   async active-high reset
//   start         in   one-cycle frame request (ignored while busy)
//   busy          out  frame in progress
//   done          out  one-cycle pulse after last CRC bit transfers
//   mem_rd_en     out  config store read strobe
//   mem_addr      out  config store read address
//   mem_rdata     in   read data, valid one cycle after mem_rd_en
//   serial_out    out  current stream bit
//   serial_valid  out  serial_out holds a valid bit
//   serial_ready  in   sink accepts the bit
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_IDLE  | waiting for start
// ST_HDR   | shifting the 8 header bits
// ST_FETCH | read strobe for word word_idx
// ST_WAIT  | store data arrives, loaded into shift register
// ST_SHIFT | shifting WORD_W payload bits, CRC accumulating
// ST_CRC   | shifting the 8 CRC bits
// ST_DONE  | done pulse, back to idle
module lut_cfg_readback
  import lut_cfg_pkg::*;
#(
  parameter int NUM_WORDS = DEF_NUM_WORDS,
  parameter int WORD_W    = DEF_WORD_W,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              serial_out,
  output logic              serial_valid,
  input  logic              serial_ready
);

  localparam int CNT_W = $clog2(WORD_W + 1);

  rb_state_t         state, state_nx;
  logic [CNT_W-1:0]  bit_cnt;
  logic [WORD_W-1:0] shreg;
  logic [ADDR_W-1:0] word_idx;
  logic [7:0]        crc_val;
  logic [2:0]        byte_idx;
  logic              xfer;
  logic              last_bit;
  logic              last_word;
  logic              crc_clr;
  logic              crc_en;

  // bit_cnt counts down the bits still to send in the current field.
  assign xfer      = serial_valid & serial_ready;
  assign last_bit  = (bit_cnt == CNT_W'(1));
  assign last_word = (word_idx == ADDR_W'(NUM_WORDS - 1));
  assign byte_idx  = 3'(bit_cnt - CNT_W'(1));
  assign mem_addr  = word_idx;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    busy         = 1'b0;
    done         = 1'b0;
    mem_rd_en    = 1'b0;
    serial_valid = 1'b0;
    serial_out   = 1'b0;
    crc_clr      = 1'b0;
    crc_en       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          crc_clr  = 1'b1;
          state_nx = ST_HDR;
        end
      end
      ST_HDR: begin
        busy         = 1'b1;
        serial_valid = 1'b1;
        serial_out   = CFG_HDR[byte_idx];
        if (xfer && last_bit) state_nx = ST_FETCH;
      end
      ST_FETCH: begin
        busy      = 1'b1;
        mem_rd_en = 1'b1;
        state_nx  = ST_WAIT;
      end
      ST_WAIT: begin
        busy     = 1'b1;
        state_nx = ST_SHIFT;
      end
      ST_SHIFT: begin
        busy         = 1'b1;
        serial_valid = 1'b1;
        serial_out   = shreg[WORD_W-1];
        crc_en       = xfer;
        if (xfer && last_bit) state_nx = last_word ? ST_CRC : ST_FETCH;
      end
      ST_CRC: begin
        busy         = 1'b1;
        serial_valid = 1'b1;
        serial_out   = crc_val[byte_idx];
        if (xfer && last_bit) state_nx = ST_DONE;
      end
      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_cnt  <= '0;
      shreg    <= '0;
      word_idx <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            word_idx <= '0;
            bit_cnt  <= CNT_W'(CRC_W);
          end
        end
        ST_HDR, ST_CRC: begin
          if (xfer) bit_cnt <= bit_cnt - CNT_W'(1);
        end
        ST_WAIT: begin
          shreg   <= mem_rdata;
          bit_cnt <= CNT_W'(WORD_W);
        end
        ST_SHIFT: begin
          if (xfer) begin
            shreg <= {shreg[WORD_W-2:0], 1'b0};
            if (last_bit) begin
              // The index parks on the last word so mem_addr holds it while idle.
              if (!last_word) word_idx <= word_idx + ADDR_W'(1);
              bit_cnt <= CNT_W'(CRC_W);
            end else begin
              bit_cnt <= bit_cnt - CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // The CRC is sampled only in ST_CRC, after the last payload bit has been folded in.
  crc8_serial u_crc (
    .clock  (clock),
    .reset  (reset),
    .clear  (crc_clr),
    .en     (crc_en),
    .bit_in (shreg[WORD_W-1]),
    .crc    (crc_val)
  );

endmodule
